// File: rtl/dprintf_pkg.sv
// Shared types and constants for the teletext dprintf concentrator.
package dprintf_pkg;

  localparam int ARB_RR              = 0;
  localparam int ARB_PRIORITY        = 1;
  localparam int TELETEXT_ROW_STRIDE = 40;

  localparam int DPRINTF_ADDR_W = 16;
  localparam int DPRINTF_DATA_W = 64;

  typedef struct packed {
    logic                      valid;
    logic [DPRINTF_ADDR_W-1:0] address;
    logic [DPRINTF_DATA_W-1:0] data_0;
    logic [DPRINTF_DATA_W-1:0] data_1;
  } t_dprintf_req;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ACK
  } t_state;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dprintf_rr_arbiter.sv
// Combinational arbiter: round-robin from last_grant+1, or lowest index first.
module dprintf_rr_arbiter
  import dprintf_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0] last_grant_i,
  input  logic             priority_i,
  output logic             any_o,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    // NOTE: every output and temporary gets a default before the loop so no path infers a latch.
    any_o       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand     = priority_i ? off : (int'(last_grant_i) + 1 + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_o && valid_i[cand_idx]) begin
        any_o             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dprintf_mux.sv
// Merges N_REQ dprintf requesters onto one registered request/ack port,
// relocating each channel's address by its index times ADDR_STRIDE.
module dprintf_mux
  import dprintf_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 64,
  parameter int ADDR_STRIDE = 0,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                    clk,
  input  logic                    clk__enable,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        dprintf_req__valid,
  input  logic [N_REQ*ADDR_W-1:0] dprintf_req__address,
  input  logic [N_REQ*DATA_W-1:0] dprintf_req__data_0,
  input  logic [N_REQ*DATA_W-1:0] dprintf_req__data_1,
  output logic [N_REQ-1:0]        dprintf_ack,
  output logic                    dprintf_out_req__valid,
  output logic [ADDR_W-1:0]       dprintf_out_req__address,
  output logic [DATA_W-1:0]       dprintf_out_req__data_0,
  output logic [DATA_W-1:0]       dprintf_out_req__data_1,
  input  logic                    dprintf_out_ack
);

  localparam int IDX_W = idx_w(N_REQ);

  t_state            state_q;
  logic [IDX_W-1:0]  last_grant_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_0_q;
  logic [DATA_W-1:0] out_data_1_q;
  logic [N_REQ-1:0]  ack_q;

  logic              any_valid;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] out_addr_d;
  logic [DATA_W-1:0] out_data_0_d;
  logic [DATA_W-1:0] out_data_1_d;

  dprintf_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arbiter (
    .valid_i     (dprintf_req__valid),
    .last_grant_i(last_grant_q),
    .priority_i  (ARB_MODE == ARB_PRIORITY),
    .any_o       (any_valid),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Per-channel offset is a constant in each unrolled branch, so no multiplier.
  always_comb begin
    out_addr_d   = '0;
    out_data_0_d = '0;
    out_data_1_d = '0;
    for (int c = 0; c < N_REQ; c++) begin
      if (grant[c]) begin
        out_addr_d   = dprintf_req__address[c*ADDR_W +: ADDR_W] + ADDR_W'(c * ADDR_STRIDE);
        out_data_0_d = dprintf_req__data_0[c*DATA_W +: DATA_W];
        out_data_1_d = dprintf_req__data_1[c*DATA_W +: DATA_W];
      end
    end
  end

  // last_grant_q doubles as the index of the transfer in flight.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_0_q <= '0;
      out_data_1_q <= '0;
      ack_q        <= '0;
    end else if (clk__enable) begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            last_grant_q <= grant_idx;
            out_valid_q  <= 1'b1;
            out_addr_q   <= out_addr_d;
            out_data_0_q <= out_data_0_d;
            out_data_1_q <= out_data_1_d;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dprintf_out_ack) begin
            out_valid_q <= 1'b0;
            ack_q       <= N_REQ'(1) << last_grant_q;
            state_q     <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dprintf_ack              = ack_q;
  assign dprintf_out_req__valid   = out_valid_q;
  assign dprintf_out_req__address = out_addr_q;
  assign dprintf_out_req__data_0  = out_data_0_q;
  assign dprintf_out_req__data_1  = out_data_1_q;

endmodule

// File: tb/tb_dprintf_mux.sv
// Scoreboard bench: one round-robin instance (stride 40) and one fixed-priority
// instance (stride 0x8000), each with a scripted downstream acknowledger.
module tb_dprintf_mux;
  import dprintf_pkg::*;

  localparam int N        = 4;
  localparam int AW       = 16;
  localparam int DW       = 64;
  localparam int STRIDE_A = TELETEXT_ROW_STRIDE;
  localparam int STRIDE_B = 'h8000;

  typedef struct {
    int            dut;
    int            ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } exp_t;

  logic clk = 1'b0;
  logic clk_en;
  logic rst;

  logic [N-1:0]    req_valid [2];
  logic [N*AW-1:0] req_addr  [2];
  logic [N*DW-1:0] req_d0    [2];
  logic [N*DW-1:0] req_d1    [2];
  logic [N-1:0]    ack       [2];
  logic            ov        [2];
  logic [AW-1:0]   oaddr     [2];
  logic [DW-1:0]   od0       [2];
  logic [DW-1:0]   od1       [2];
  logic            oack      [2];

  logic            resp_ack  [2];
  logic            spur_ack  [2];
  logic            auto_en   [2];
  int              delay     [2];
  int              wcnt      [2];
  int              done      [2];
  logic [N-1:0]    pending   [2];
  logic            prev_ov   [2];
  int              last_rise [2];
  int              cyc;
  int              chk_from;
  logic            period_chk;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 2; d++) oack[d] = resp_ack[d] | spur_ack[d];
  end

  dprintf_mux #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ADDR_STRIDE(STRIDE_A), .ARB_MODE(ARB_RR)
  ) u_dut_rr (
    .clk                     (clk),
    .clk__enable             (clk_en),
    .reset                   (rst),
    .dprintf_req__valid      (req_valid[0]),
    .dprintf_req__address    (req_addr[0]),
    .dprintf_req__data_0     (req_d0[0]),
    .dprintf_req__data_1     (req_d1[0]),
    .dprintf_ack             (ack[0]),
    .dprintf_out_req__valid  (ov[0]),
    .dprintf_out_req__address(oaddr[0]),
    .dprintf_out_req__data_0 (od0[0]),
    .dprintf_out_req__data_1 (od1[0]),
    .dprintf_out_ack         (oack[0])
  );

  dprintf_mux #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ADDR_STRIDE(STRIDE_B), .ARB_MODE(ARB_PRIORITY)
  ) u_dut_pri (
    .clk                     (clk),
    .clk__enable             (clk_en),
    .reset                   (rst),
    .dprintf_req__valid      (req_valid[1]),
    .dprintf_req__address    (req_addr[1]),
    .dprintf_req__data_0     (req_d0[1]),
    .dprintf_req__data_1     (req_d1[1]),
    .dprintf_ack             (ack[1]),
    .dprintf_out_req__valid  (ov[1]),
    .dprintf_out_req__address(oaddr[1]),
    .dprintf_out_req__data_0 (od0[1]),
    .dprintf_out_req__data_1 (od1[1]),
    .dprintf_out_ack         (oack[1])
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic int stride_of(input int d);
    return (d == 0) ? STRIDE_A : STRIDE_B;
  endfunction

  task automatic set_req(input int d, input int c, input logic [AW-1:0] a,
                         input logic [DW-1:0] x0, input logic [DW-1:0] x1);
    req_addr[d][c*AW +: AW] = a;
    req_d0[d][c*DW +: DW]   = x0;
    req_d1[d][c*DW +: DW]   = x1;
  endtask

  // Expected transfer: address relocated by channel*stride, wrapping at 2^AW.
  task automatic push(input int d, input int c);
    exp_t e;
    e.dut  = d;
    e.ch   = c;
    e.addr = req_addr[d][c*AW +: AW] + AW'(c * stride_of(d));
    e.d0   = req_d0[d][c*DW +: DW];
    e.d1   = req_d1[d][c*DW +: DW];
    sb.push_back(e);
  endtask

  task automatic wait_done(input int d, input int n, input int budget);
    int i;
    i = 0;
    while (done[d] < n && i < budget) begin
      tick();
      i++;
    end
    if (done[d] < n) check("timeout_ack", 64'(done[d]), 64'(n));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, scoreboard pop and downstream acknowledger.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ov[d] === 1'b1 && prev_ov[d] !== 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          check("sb_dut", 64'(d), 64'(sb[0].dut));
          check("out_addr", 64'(oaddr[d]), 64'(sb[0].addr));
          check("out_d0", od0[d], sb[0].d0);
          check("out_d1", od1[d], sb[0].d1);
          pending[d] <= N'(1) << sb[0].ch;
          void'(sb.pop_front());
        end
        if (period_chk && last_rise[d] >= chk_from) check("grant_period", 64'(cyc - last_rise[d]), 64'd3);
        last_rise[d] <= cyc;
      end
      if (resp_ack[d]) begin
        check("ovld_drop", 64'(ov[d]), 64'd0);
        check("req_ack", 64'(ack[d]), 64'(pending[d]));
        done[d]     <= done[d] + 1;
        resp_ack[d] <= 1'b0;
      end else begin
        if (ack[d] !== '0) check("ack_spur", 64'(ack[d]), 64'd0);
        if (ov[d] !== 1'b1) begin
          wcnt[d] <= 0;
        end else if (auto_en[d] && !rst) begin
          if (wcnt[d] == delay[d]) begin
            resp_ack[d] <= 1'b1;
            wcnt[d]     <= 0;
          end else begin
            wcnt[d] <= wcnt[d] + 1;
          end
        end
      end
      prev_ov[d] <= ov[d];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    cyc        = 0;
    chk_from   = 0;
    period_chk = 1'b0;
    clk_en     = 1'b1;
    rst        = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_addr[d]  = '0;
      req_d0[d]    = '0;
      req_d1[d]    = '0;
      resp_ack[d]  = 1'b0;
      spur_ack[d]  = 1'b0;
      auto_en[d]   = 1'b0;
      delay[d]     = 0;
      wcnt[d]      = 0;
      done[d]      = 0;
      pending[d]   = '0;
      last_rise[d] = -1000;
    end
    idle(2);
    for (int d = 0; d < 2; d++) begin
      check("rst_ov", 64'(ov[d]), 64'd0);
      check("rst_addr", 64'(oaddr[d]), 64'd0);
      check("rst_d0", od0[d], 64'd0);
      check("rst_ack", 64'(ack[d]), 64'd0);
    end
    rst = 1'b0;
    idle(2);

    // Round-robin fairness: all channels held valid, immediate downstream ack.
    for (int c = 0; c < N; c++)
      set_req(0, c, AW'(16'h0100 * c + 16'h0010), {$urandom, $urandom}, {$urandom, $urandom});
    for (int k = 0; k < 5; k++) push(0, k % N);
    base       = done[0];
    chk_from   = cyc;
    period_chk = 1'b1;
    auto_en[0] = 1'b1;
    delay[0]   = 0;
    req_valid[0] = 4'hF;
    wait_done(0, base + 5, 100);
    req_valid[0] = '0;
    period_chk   = 1'b0;
    idle(4);

    // Single request on ch2, downstream acks two cycles after out valid.
    set_req(0, 2, 16'h0005, 64'h41424344_00000000, 64'h0123_4567_89ab_cdef);
    push(0, 2);
    delay[0] = 2;
    base = done[0];
    req_valid[0] = 4'b0100;
    check("lat_pre", 64'(ov[0]), 64'd0);
    tick();
    check("lat_e1", 64'(ov[0]), 64'd1);
    check("addr_0055", 64'(oaddr[0]), 64'h0055);
    tick();
    check("busy_hold", 64'(ov[0]), 64'd1);
    wait_done(0, base + 1, 20);
    req_valid[0] = '0;
    idle(3);

    // Spurious downstream ack while IDLE, then again while in ACK.
    auto_en[0]  = 1'b0;
    spur_ack[0] = 1'b1;
    tick();
    spur_ack[0] = 1'b0;
    idle(2);
    check("spur_idle_ov", 64'(ov[0]), 64'd0);
    check("spur_idle_ack", 64'(ack[0]), 64'd0);
    set_req(0, 1, 16'h0777, {$urandom, $urandom}, {$urandom, $urandom});
    push(0, 1);
    auto_en[0] = 1'b1;
    delay[0]   = 0;
    base = done[0];
    req_valid[0] = 4'b0010;
    tick();
    check("spur_grant", 64'(ov[0]), 64'd1);
    tick();
    check("spur_ack_pulse", 64'(ack[0]), 64'b0010);
    spur_ack[0] = 1'b1;
    tick();
    spur_ack[0]  = 1'b0;
    req_valid[0] = '0;
    check("spur_ack_end", 64'(ack[0]), 64'd0);
    check("spur_ack_ov", 64'(ov[0]), 64'd0);
    idle(2);
    check("spur_after_ov", 64'(ov[0]), 64'd0);
    check("spur_done", 64'(done[0]), 64'(base + 1));

    // Reset in BUSY aborts the transfer; ch0 wins first again afterwards.
    auto_en[0] = 1'b0;
    set_req(0, 0, 16'h0042, {$urandom, $urandom}, {$urandom, $urandom});
    set_req(0, 1, 16'h0099, {$urandom, $urandom}, {$urandom, $urandom});
    push(0, 0);
    req_valid[0] = 4'b0011;
    tick();
    check("abort_grant", 64'(ov[0]), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ov", 64'(ov[0]), 64'd0);
    check("abort_ack", 64'(ack[0]), 64'd0);
    check("abort_addr", 64'(oaddr[0]), 64'd0);
    push(0, 0);
    push(0, 1);
    tick();
    check("reidle_grant", 64'(ov[0]), 64'd1);
    base = done[0];
    auto_en[0] = 1'b1;
    wait_done(0, base + 1, 20);
    req_valid[0] = 4'b0010;
    wait_done(0, base + 2, 20);
    req_valid[0] = '0;
    idle(4);

    // Fixed priority: ch1 starves ch3 until ch1 drops.
    set_req(1, 1, 16'h0200, {$urandom, $urandom}, {$urandom, $urandom});
    set_req(1, 3, 16'h0030, {$urandom, $urandom}, {$urandom, $urandom});
    push(1, 1);
    push(1, 1);
    push(1, 3);
    auto_en[1] = 1'b1;
    delay[1]   = 0;
    base = done[1];
    req_valid[1] = 4'b1010;
    wait_done(1, base + 2, 40);
    req_valid[1] = 4'b1000;
    wait_done(1, base + 3, 40);
    req_valid[1] = '0;
    idle(4);

    // Address wrap: 0x9000 + 1*0x8000 truncates to 0x1000.
    set_req(1, 1, 16'h9000, {$urandom, $urandom}, {$urandom, $urandom});
    push(1, 1);
    delay[1] = 1;
    base = done[1];
    req_valid[1] = 4'b0010;
    tick();
    check("wrap_addr", 64'(oaddr[1]), 64'h1000);
    wait_done(1, base + 1, 20);
    req_valid[1] = '0;
    idle(4);

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
